// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction buffer between IFetch and the decoder. Each entry holds a fetched
//   instruction word and its PC+4 so that decode stalls never drop instructions.
//   It is a circular FIFO with a valid/ready handshake on both sides. Reads are
//   combinational from the head entry. A redirect (flush) discards every held word
//   and the word offered in the same cycle.
//
//   Optional feature macro: FETCH_QUEUE_BYPASS_EN
//     When it is defined, an empty queue forwards the incoming word straight to the
//     deq_* outputs. If the decoder takes it in that cycle, the word is never written.
//
// Parameters
//   DEPTH      number of entries (power of two, >= 2)
//   ISA_WIDTH  width of the instruction word and of PC+4
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous reset, active low (0 = in reset)
//   enq_valid  in   IFetch presents a word this cycle
//   enq_ready  out  queue accepts a word this cycle
//   enq_inst   in   fetched instruction
//   enq_pc4    in   PC+4 of the fetched instruction
//   flush      in   redirect: discard all held and incoming words
//   deq_valid  out  head entry valid for decode
//   deq_ready  in   decoder consumes the head this cycle
//   deq_inst   out  head instruction, zero (NOP) when not valid
//   deq_pc4    out  head PC+4, zero when not valid
//   count      out  number of entries held

module fetch_queue #(
    parameter int DEPTH     = 4,
    parameter int ISA_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [ISA_WIDTH-1:0]   enq_inst,
    input  logic [ISA_WIDTH-1:0]   enq_pc4,
    input  logic                   flush,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [ISA_WIDTH-1:0]   deq_inst,
    output logic [ISA_WIDTH-1:0]   deq_pc4,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ISA_WIDTH-1:0] r_inst [DEPTH];
    logic [ISA_WIDTH-1:0] r_pc4  [DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic w_live;
    logic w_empty;
    logic w_full;
    logic w_head_valid;
    logic w_pass;
    logic w_bypass;
    logic w_enq_fire;
    logic w_deq_fire;
    logic w_do_write;
    logic w_do_read;

    // The reset level gates every handshake output, so the outputs drop as soon as
    // reset goes low and do not wait for a clock edge.
    assign w_live       = reset && !flush;
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_head_valid = w_live && !w_empty;

`ifdef FETCH_QUEUE_BYPASS_EN
    // On an empty queue the offered word is shown on deq_* at once. It is only
    // kept out of storage when the decoder actually takes it this cycle.
    assign w_pass   = w_live && w_empty && enq_valid;
    assign w_bypass = w_pass && deq_ready;
`else
    assign w_pass   = 1'b0;
    assign w_bypass = 1'b0;
`endif

    // A full queue never accepts a word, even when the head leaves in the same cycle.
    assign enq_ready  = w_live && !w_full;
    assign deq_valid  = w_head_valid || w_pass;
    assign w_enq_fire = enq_valid && enq_ready;
    assign w_deq_fire = deq_valid && deq_ready;
    assign w_do_write = w_enq_fire && !w_bypass;
    assign w_do_read  = w_deq_fire && !w_bypass;
    assign count      = r_count;

    // Head data is forced to zero whenever nothing valid is presented.
    always_comb begin
        deq_inst = '0;
        deq_pc4  = '0;
        if (w_pass) begin
            deq_inst = enq_inst;
            deq_pc4  = enq_pc4;
        end else if (w_head_valid) begin
            deq_inst = r_inst[r_rd_ptr];
            deq_pc4  = r_pc4[r_rd_ptr];
        end
    end

    // Storage has no reset. Stale entries are unreachable once the pointers and
    // the count are cleared.
    always_ff @(posedge clock) begin
        if (w_do_write) begin
            r_inst[r_wr_ptr] <= enq_inst;
            r_pc4[r_wr_ptr]  <= enq_pc4;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. Full and empty come
    // from the count alone. A flush drops the contents by moving the read pointer
    // onto the write pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_do_write) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_read) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_do_write && !w_do_read) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_read && !w_do_write) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
